latq_bank: RTL and testbench

LATQ_BANK -- requirements
Module: latq_bank

---
 rtl/latq_bank_pkg.sv | 18 +
 rtl/latq_bank_chan.sv | 51 +++++
 rtl/latq_bank.sv | 70 +++++++
 tb/tb_latq_bank.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/latq_bank_pkg.sv
// Shared constants and the bus-slicing helper for the latch-queue bank.
// The helper widens any packed bus to the largest legal size so a single function serves every parameterisation.
package latq_bank_pkg;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = 15;
   localparam int MAX_W   = 32;
   localparam int MAX_BUS = 512;

   function automatic logic [MAX_W-1:0] chan_slice(input logic [MAX_BUS-1:0] bus,
                                                   input int width,
                                                   input int idx);
      logic [MAX_BUS-1:0] shifted;
      shifted = bus >> (width * idx);
      return shifted[MAX_W-1:0];
   endfunction

endpackage

// File: rtl/latq_bank_chan.sv
// One latch channel: the shadow register, the registered active flag,
// the sticky hold-violation flag and the saturating count of closing events.
module latq_bank_chan
   import latq_bank_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int E_POL = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             e,
   input  logic [WIDTH-1:0] d,
   input  logic             clr_viol,
   output logic [WIDTH-1:0] s,
   output logic             viol,
   output logic [CNT_W-1:0] capcnt
);

   localparam logic POL = 1'(E_POL);

   logic active;
   logic active_q;
   logic closing;

   assign active  = ~(e ^ POL);
   assign closing = active_q & ~active;

   // A new violation takes priority over a same-cycle clear so that no event is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         s        <= '0;
         viol     <= 1'b0;
         capcnt   <= '0;
      end else begin
         active_q <= active;
         if (active) begin
            s <= d;
         end
         if (closing && (d != s)) begin
            viol <= 1'b1;
         end else if (clr_viol) begin
            viol <= 1'b0;
         end
         if (closing && (capcnt != CNT_W'(CNT_MAX))) begin
            capcnt <= capcnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/latq_bank.sv
// Bank of independent clocked latch channels with an optional double-buffered output
// that only moves when COMMIT is asserted.
module latq_bank
   import latq_bank_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int E_POL    = 1,
   parameter int DBUF     = 0
) (
   input  logic                      CLK,
   input  logic                      RN,
   input  logic [CHANNELS-1:0]       E,
   input  logic [CHANNELS*WIDTH-1:0] D,
   input  logic                      COMMIT,
   input  logic                      CLR_VIOL,
   output logic [CHANNELS*WIDTH-1:0] Q,
   output logic [CHANNELS-1:0]       VIOL,
   output logic [CHANNELS*CNT_W-1:0] CAPCNT
);

   if (WIDTH < 1 || WIDTH > MAX_W) begin : g_bad_width
      $fatal(1, "latq_bank: WIDTH must be in 1..32");
   end
   if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
      $fatal(1, "latq_bank: CHANNELS must be in 1..16");
   end
   if (E_POL != 0 && E_POL != 1) begin : g_bad_pol
      $fatal(1, "latq_bank: E_POL must be 0 or 1");
   end
   if (DBUF != 0 && DBUF != 1) begin : g_bad_dbuf
      $fatal(1, "latq_bank: DBUF must be 0 or 1");
   end

   logic [CHANNELS*WIDTH-1:0] shadow;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      latq_bank_chan #(
         .WIDTH (WIDTH),
         .E_POL (E_POL)
      ) u_chan (
         .clk      (CLK),
         .rst_n    (RN),
         .e        (E[i]),
         .d        (WIDTH'(chan_slice(MAX_BUS'(D), WIDTH, i))),
         .clr_viol (CLR_VIOL),
         .s        (shadow[i*WIDTH +: WIDTH]),
         .viol     (VIOL[i]),
         .capcnt   (CAPCNT[i*CNT_W +: CNT_W])
      );
   end

   if (DBUF == 1) begin : g_dbuf
      logic [CHANNELS*WIDTH-1:0] q_reg;

      // The copy takes the pre-edge shadow, so a load coinciding with COMMIT waits for the next one.
      always_ff @(posedge CLK or negedge RN) begin
         if (!RN) begin
            q_reg <= '0;
         end else if (COMMIT) begin
            q_reg <= shadow;
         end
      end

      assign Q = q_reg;
   end else begin : g_direct
      assign Q = shadow;
   end

endmodule

// File: tb/tb_latq_bank.sv
// Scoreboard bench driving four latq_bank configurations side by side against a
// per-channel behavioural model of the latch rules.
module tb_latq_bank;

   localparam int ND = 4;

   typedef struct packed {
      logic [1:0]   dut;
      logic [511:0] q;
      logic [15:0]  viol;
      logic [63:0]  cap;
   } obs_t;

   int cfg_w    [ND] = '{8, 8, 1, 32};
   int cfg_c    [ND] = '{4, 4, 16, 1};
   int cfg_pol  [ND] = '{1, 0, 1, 1};
   int cfg_dbuf [ND] = '{0, 1, 0, 0};

   logic clk = 1'b0;
   logic rn = 1'b0;
   logic commit = 1'b0;
   logic clr_viol = 1'b0;

   logic [15:0] e_in [ND];
   logic [31:0] d_in [ND][16];

   logic [3:0]  e0, e1, viol0, viol1;
   logic [31:0] d0, d1, q0, q1;
   logic [15:0] cap0, cap1;
   logic [15:0] e2, d2, q2, viol2;
   logic [63:0] cap2;
   logic [0:0]  e3, viol3;
   logic [31:0] d3, q3;
   logic [3:0]  cap3;

   logic [31:0] m_s    [ND][16];
   logic [31:0] m_q    [ND][16];
   bit          m_prev [ND][16];
   bit          m_viol [ND][16];
   int          m_cnt  [ND][16];

   obs_t exp_q [$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   latq_bank #(.WIDTH(8), .CHANNELS(4), .E_POL(1), .DBUF(0)) dut0 (
      .CLK(clk), .RN(rn), .E(e0), .D(d0), .COMMIT(commit), .CLR_VIOL(clr_viol),
      .Q(q0), .VIOL(viol0), .CAPCNT(cap0));
   latq_bank #(.WIDTH(8), .CHANNELS(4), .E_POL(0), .DBUF(1)) dut1 (
      .CLK(clk), .RN(rn), .E(e1), .D(d1), .COMMIT(commit), .CLR_VIOL(clr_viol),
      .Q(q1), .VIOL(viol1), .CAPCNT(cap1));
   latq_bank #(.WIDTH(1), .CHANNELS(16), .E_POL(1), .DBUF(0)) dut2 (
      .CLK(clk), .RN(rn), .E(e2), .D(d2), .COMMIT(commit), .CLR_VIOL(clr_viol),
      .Q(q2), .VIOL(viol2), .CAPCNT(cap2));
   latq_bank #(.WIDTH(32), .CHANNELS(1), .E_POL(1), .DBUF(0)) dut3 (
      .CLK(clk), .RN(rn), .E(e3), .D(d3), .COMMIT(commit), .CLR_VIOL(clr_viol),
      .Q(q3), .VIOL(viol3), .CAPCNT(cap3));

   always_comb begin
      e0 = e_in[0][3:0];
      e1 = e_in[1][3:0];
      e2 = e_in[2];
      e3 = e_in[3][0:0];
      d0 = '0;
      d1 = '0;
      d2 = '0;
      for (int c = 0; c < 4; c++) begin
         d0[c*8 +: 8] = d_in[0][c][7:0];
         d1[c*8 +: 8] = d_in[1][c][7:0];
      end
      for (int c = 0; c < 16; c++) begin
         d2[c] = d_in[2][c][0];
      end
      d3 = d_in[3][0];
   end

   function automatic logic [31:0] width_mask(int w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
   endfunction

   task automatic set_idle();
      for (int k = 0; k < ND; k++) begin
         e_in[k] = (cfg_pol[k] == 1) ? 16'h0000 : 16'hFFFF;
         for (int c = 0; c < 16; c++) d_in[k][c] = '0;
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < ND; k++) begin
         for (int c = 0; c < 16; c++) begin
            m_s[k][c] = '0;
            m_q[k][c] = '0;
            m_prev[k][c] = 1'b0;
            m_viol[k][c] = 1'b0;
            m_cnt[k][c] = 0;
         end
      end
   endtask

   // One rising edge of the reference: close detection compares against the value being held.
   task automatic model_edge();
      for (int k = 0; k < ND; k++) begin
         for (int c = 0; c < cfg_c[k]; c++) begin
            bit act;
            bit closing;
            logic [31:0] held;
            act = (int'(e_in[k][c]) == cfg_pol[k]);
            closing = m_prev[k][c] && !act;
            held = m_s[k][c];
            if (closing && (d_in[k][c] != held)) m_viol[k][c] = 1'b1;
            else if (clr_viol) m_viol[k][c] = 1'b0;
            if (closing && m_cnt[k][c] < 15) m_cnt[k][c] = m_cnt[k][c] + 1;
            if (act) m_s[k][c] = d_in[k][c];
            if (cfg_dbuf[k] == 1 && commit) m_q[k][c] = held;
            m_prev[k][c] = act;
         end
      end
   endtask

   task automatic push_expected();
      for (int k = 0; k < ND; k++) begin
         obs_t o;
         o = '0;
         o.dut = 2'(k);
         for (int c = 0; c < cfg_c[k]; c++) begin
            logic [31:0] qv;
            qv = (cfg_dbuf[k] == 1) ? m_q[k][c] : m_s[k][c];
            o.q = o.q | (512'(qv) << (c * cfg_w[k]));
            o.viol[c] = m_viol[k][c];
            o.cap = o.cap | (64'(m_cnt[k][c]) << (c * 4));
         end
         exp_q.push_back(o);
      end
   endtask

   function automatic obs_t get_actual(int k);
      obs_t o;
      o = '0;
      o.dut = 2'(k);
      case (k)
         0: begin o.q = 512'(q0); o.viol = 16'(viol0); o.cap = 64'(cap0); end
         1: begin o.q = 512'(q1); o.viol = 16'(viol1); o.cap = 64'(cap1); end
         2: begin o.q = 512'(q2); o.viol = 16'(viol2); o.cap = 64'(cap2); end
         default: begin o.q = 512'(q3); o.viol = 16'(viol3); o.cap = 64'(cap3); end
      endcase
      return o;
   endfunction

   // Called just after a rising edge: the expectation covers the window up to the next edge.
   task automatic applyStimulus();
      if (!rn) model_reset();
      push_expected();
      @(posedge clk);
      #1;
      if (rn) model_edge();
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: compares every queued expectation on the falling edge.
   initial begin
      obs_t exp_o;
      obs_t act_o;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            exp_o = exp_q.pop_front();
            act_o = get_actual(int'(exp_o.dut));
            checks += 3;
            if (act_o.q !== exp_o.q) begin
               errors++;
               $display("[TB] FAIL dut%0d_q t=%0t actual=%h required=%h", exp_o.dut, $time, act_o.q, exp_o.q);
            end
            if (act_o.viol !== exp_o.viol) begin
               errors++;
               $display("[TB] FAIL dut%0d_viol t=%0t actual=%h required=%h", exp_o.dut, $time, act_o.viol, exp_o.viol);
            end
            if (act_o.cap !== exp_o.cap) begin
               errors++;
               $display("[TB] FAIL dut%0d_capcnt t=%0t actual=%h required=%h", exp_o.dut, $time, act_o.cap, exp_o.cap);
            end
         end
      end
   end

   initial begin
      set_idle();
      model_reset();
      @(posedge clk);
      #1;
      applyStimulus();
      applyStimulus();
      checkOutput("reset_q0", q0, 32'h0);
      checkOutput("reset_cap0", 32'(cap0), 32'h0);
      rn = 1'b1;
      applyStimulus();

      // Capture and close on dut0 channel 0.
      e_in[0][0] = 1'b1;
      d_in[0][0] = 32'h11; applyStimulus();
      d_in[0][0] = 32'h22; applyStimulus();
      d_in[0][0] = 32'h33; applyStimulus();
      e_in[0][0] = 1'b0;   applyStimulus();
      checkOutput("close_q0", 32'(q0[7:0]), 32'h33);
      checkOutput("close_viol0", 32'(viol0[0]), 32'h0);
      checkOutput("close_cap0", 32'(cap0[3:0]), 32'h1);

      // Hold violation, clear, and clear losing to a new violation on channel 1.
      e_in[0][1] = 1'b1; d_in[0][1] = 32'h5A; applyStimulus();
      e_in[0][1] = 1'b0; d_in[0][1] = 32'hA5; applyStimulus();
      checkOutput("viol_q1", 32'(q0[15:8]), 32'h5A);
      checkOutput("viol_set1", 32'(viol0[1]), 32'h1);
      clr_viol = 1'b1; applyStimulus();
      clr_viol = 1'b0;
      checkOutput("viol_clr1", 32'(viol0[1]), 32'h0);
      e_in[0][1] = 1'b1; d_in[0][1] = 32'h10; applyStimulus();
      e_in[0][1] = 1'b0; d_in[0][1] = 32'h20; clr_viol = 1'b1; applyStimulus();
      clr_viol = 1'b0;
      checkOutput("viol_wins1", 32'(viol0[1]), 32'h1);

      // Saturation on channel 2.
      d_in[0][2] = 32'h3C;
      for (int n = 0; n < 20; n++) begin
         e_in[0][2] = 1'b1; applyStimulus();
         e_in[0][2] = 1'b0; applyStimulus();
      end
      checkOutput("sat_cap2", 32'(cap0[11:8]), 32'd15);

      // Double-buffered, active-low enable on dut1 channel 3.
      e_in[1][3] = 1'b0; d_in[1][3] = 32'h7E; applyStimulus();
      e_in[1][3] = 1'b1; applyStimulus();
      checkOutput("dbuf_hold", 32'(q1[31:24]), 32'h0);
      commit = 1'b1; applyStimulus();
      commit = 1'b0;
      checkOutput("dbuf_commit", 32'(q1[31:24]), 32'h7E);
      e_in[1][3] = 1'b0; d_in[1][3] = 32'h81; commit = 1'b1; applyStimulus();
      commit = 1'b0;
      checkOutput("dbuf_coincide", 32'(q1[31:24]), 32'h7E);
      e_in[1][3] = 1'b1; d_in[1][3] = 32'h81; applyStimulus();
      commit = 1'b1; applyStimulus();
      commit = 1'b0;
      checkOutput("dbuf_next", 32'(q1[31:24]), 32'h81);

      // Reset in the middle of an active window, coincident with COMMIT.
      e_in[0][0] = 1'b1; d_in[0][0] = 32'h44; applyStimulus();
      rn = 1'b0;
      commit = 1'b1;
      #1;
      checkOutput("rst_q0", q0, 32'h0);
      checkOutput("rst_viol0", 32'(viol0), 32'h0);
      checkOutput("rst_cap0", 32'(cap0), 32'h0);
      checkOutput("rst_q1", q1, 32'h0);
      applyStimulus();
      commit = 1'b0;
      rn = 1'b1;
      applyStimulus();
      applyStimulus();
      checkOutput("rel_cap0", 32'(cap0[3:0]), 32'h0);
      checkOutput("rel_q0", 32'(q0[7:0]), 32'h44);
      e_in[0][0] = 1'b0; applyStimulus();
      checkOutput("rel_close_cap0", 32'(cap0[3:0]), 32'h1);

      // Random traffic on every channel of every configuration.
      for (int n = 0; n < 1000; n++) begin
         for (int k = 0; k < ND; k++) begin
            for (int c = 0; c < cfg_c[k]; c++) begin
               e_in[k][c] = 1'($urandom_range(0, 1));
               if ($urandom_range(0, 1) == 1) d_in[k][c] = $urandom & width_mask(cfg_w[k]);
            end
         end
         commit   = ($urandom_range(0, 3) == 0);
         clr_viol = ($urandom_range(0, 7) == 0);
         applyStimulus();
      end
      commit = 1'b0;
      clr_viol = 1'b0;

      push_expected();
      @(negedge clk);
      #1;
      checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
